// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - state encoding and default sizes shared by the FIR RAM-control path
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PRIME,
    ST_LOAD,
    ST_SETTLE,
    ST_WAIT,
    ST_READ
  } state_t;

  localparam int DEF_NUM_TAPS = 33;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_DATA_W   = 16;

  // Number of host beats needed for a symmetric table.
  function automatic int half_taps(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/tap_addr_counter.sv
// rtl/tap_addr_counter.sv - mod-N tap counter with clear, enable and terminal count
module tap_addr_counter #(
  parameter int P_N = 33,
  parameter int P_W = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  input  logic           i_en,
  output logic [P_W-1:0] o_cnt,
  output logic           o_tc
);

  localparam logic [P_W-1:0] LP_LAST = P_W'(P_N - 1);

  logic [P_W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LP_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coeff_update_sequencer.sv
// rtl/coeff_update_sequencer.sv - coefficient-load and tap-read RAM command sequencer
// COEFF_SYMM_EN: host sends half the table; each beat is mirrored to tap N-1-k.
module coeff_update_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int P_NUM_TAPS = DEF_NUM_TAPS,
  parameter int P_ADDR_W   = DEF_ADDR_W,
  parameter int P_DATA_W   = DEF_DATA_W
) (
  input  logic                       iClk_12M,
  input  logic                       iRst,
  input  logic                       iUpdReq,
  input  logic                       iCoeffValid,
  input  logic signed [P_DATA_W-1:0] iCoeffData,
  output logic                       oCoeffReady,
  input  logic                       iSampleValid,
  output logic                       oCoeffiUpdateFlag,
  output logic                       oCsnRam,
  output logic                       oWrnRam,
  output logic        [P_ADDR_W-1:0] oAddrRam,
  output logic signed [P_DATA_W-1:0] oWrDtRam,
  output logic                       oBusy,
  output logic                       oSweepDone,
  output logic                       oOverrun
);

  localparam logic [P_ADDR_W-1:0] LP_LAST_ADDR = P_ADDR_W'(P_NUM_TAPS - 1);

  state_t                       r_state;
  logic                         r_flag, r_csn, r_wrn, r_ready, r_busy, r_done, r_overrun, r_upd_pend;
  logic        [P_ADDR_W-1:0]   r_addr;
  logic signed [P_DATA_W-1:0]   r_data;
  logic        [P_ADDR_W-1:0]   w_cnt;
  logic                         w_tc, w_hs, w_cnt_en, w_cnt_clr, w_go_arm;

  assign w_hs     = (r_state == ST_LOAD) && r_ready && iCoeffValid;
  assign w_cnt_en = w_hs || ((r_state == ST_READ) && !r_done)
                 || ((r_state == ST_WAIT) && iSampleValid && !iUpdReq);
  // A sweep's final cycle also honours a request arriving on that very cycle.
  assign w_go_arm = (iUpdReq && ((r_state == ST_IDLE) || (r_state == ST_WAIT)))
                 || ((r_state == ST_READ) && r_done && (r_upd_pend || iUpdReq));

`ifdef COEFF_SYMM_EN
  localparam logic [P_ADDR_W-1:0] LP_LAST_BEAT = P_ADDR_W'(half_taps(P_NUM_TAPS) - 1);
  logic r_mirror, r_last_beat;
  assign w_cnt_clr = (r_state == ST_ARM) || (w_hs && (w_cnt == LP_LAST_BEAT));
`else
  assign w_cnt_clr = (r_state == ST_ARM);
`endif

  tap_addr_counter #(.P_N(P_NUM_TAPS), .P_W(P_ADDR_W)) u_tap_cnt (
    .i_clk (iClk_12M),
    .i_rst (iRst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      r_state    <= ST_IDLE;
      r_flag     <= 1'b0;
      r_csn      <= 1'b1;
      r_wrn      <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_upd_pend <= 1'b0;
`ifdef COEFF_SYMM_EN
      r_mirror    <= 1'b0;
      r_last_beat <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      // r_busy is high exactly in ARM..SETTLE and READ, where a strobe cannot be served.
      if (iSampleValid && (r_busy || ((r_state == ST_WAIT) && iUpdReq)))
        r_overrun <= 1'b1;
      case (r_state)
        ST_WAIT: begin
          if (iSampleValid && !iUpdReq) begin
            r_state <= ST_READ;
            r_busy  <= 1'b1;
            r_csn   <= 1'b0;
            r_addr  <= w_cnt;
          end
        end
        ST_ARM: begin
          r_state <= ST_PRIME;
          r_csn   <= 1'b0;
          r_addr  <= '0;
          r_data  <= '0;
        end
        ST_PRIME: begin
          r_state <= ST_LOAD;
          r_csn   <= 1'b1;
          r_ready <= 1'b1;
        end
        ST_LOAD: begin
`ifdef COEFF_SYMM_EN
          if (r_mirror) begin
            r_csn    <= 1'b0;
            r_addr   <= LP_LAST_ADDR - r_addr;
            r_mirror <= 1'b0;
            if (r_last_beat) r_state <= ST_SETTLE;
            else             r_ready <= 1'b1;
          end else if (w_hs) begin
            r_csn   <= 1'b0;
            r_addr  <= w_cnt;
            r_data  <= iCoeffData;
            r_ready <= 1'b0;
            if (w_cnt == LP_LAST_ADDR - w_cnt) begin
              r_state <= ST_SETTLE;
            end else begin
              r_mirror    <= 1'b1;
              r_last_beat <= (w_cnt == LP_LAST_BEAT);
            end
          end else begin
            r_csn <= 1'b1;
          end
`else
          if (w_hs) begin
            r_csn  <= 1'b0;
            r_addr <= w_cnt;
            r_data <= iCoeffData;
            if (w_tc) begin
              r_state <= ST_SETTLE;
              r_ready <= 1'b0;
            end
          end else begin
            r_csn <= 1'b1;
          end
`endif
        end
        ST_SETTLE: begin
          r_state <= ST_WAIT;
          r_flag  <= 1'b0;
          r_csn   <= 1'b1;
          r_wrn   <= 1'b1;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
        ST_READ: begin
          if (iUpdReq) r_upd_pend <= 1'b1;
          if (r_done) begin
            r_state <= ST_WAIT;
            r_csn   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_addr <= w_cnt;
            if (w_tc) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_go_arm) begin
        r_state    <= ST_ARM;
        r_flag     <= 1'b1;
        r_csn      <= 1'b1;
        r_wrn      <= 1'b0;
        r_ready    <= 1'b0;
        r_busy     <= 1'b1;
        r_upd_pend <= 1'b0;
      end
    end
  end

  assign oCoeffiUpdateFlag = r_flag;
  assign oCsnRam           = r_csn;
  assign oWrnRam           = r_wrn;
  assign oAddrRam          = r_addr;
  assign oWrDtRam          = r_data;
  assign oCoeffReady       = r_ready;
  assign oBusy             = r_busy;
  assign oSweepDone        = r_done;
  assign oOverrun          = r_overrun;

endmodule

// File: tb/tb_coeff_update_sequencer.sv
// tb/tb_coeff_update_sequencer.sv - directed self-checking bench for coeff_update_sequencer
module tb_coeff_update_sequencer;

  localparam int N = 33;
  // Control vector order: {flag, csn, wrn, ready, busy}
  localparam logic [4:0] S_IDLE  = 5'b01100;
  localparam logic [4:0] S_ARM   = 5'b11001;
  localparam logic [4:0] S_PRIME = 5'b10001;
  localparam logic [4:0] S_LHOLD = 5'b11011;
  localparam logic [4:0] S_LWR   = 5'b10011;
  localparam logic [4:0] S_LLAST = 5'b10001;
  localparam logic [4:0] S_WAIT  = 5'b01100;
  localparam logic [4:0] S_READ  = 5'b00101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic        cv  = 1'b0;
  logic        sv  = 1'b0;
  logic [15:0] cd  = '0;
  logic        rdy, flag, csn, wrn, busy, done, ovr;
  logic [5:0]  addr;
  logic [15:0] wdat;
  logic [4:0]  ctl;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign ctl = {flag, csn, wrn, rdy, busy};

  always #5 clk = ~clk;

  coeff_update_sequencer dut (
    .iClk_12M          (clk),
    .iRst              (rst),
    .iUpdReq           (upd),
    .iCoeffValid       (cv),
    .iCoeffData        (cd),
    .oCoeffReady       (rdy),
    .iSampleValid      (sv),
    .oCoeffiUpdateFlag (flag),
    .oCsnRam           (csn),
    .oWrnRam           (wrn),
    .oAddrRam          (addr),
    .oWrDtRam          (wdat),
    .oBusy             (busy),
    .oSweepDone        (done),
    .oOverrun          (ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ctl, done, ovr} !== {S_IDLE, 2'b00}) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", {ctl, done, ovr}, {S_IDLE, 2'b00});
    end
    n_checks++;
    if ({addr, wdat} !== 22'd0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", addr, wdat);
    end
    rst = 1'b0;
    tick();
    sv = 1'b1;
    tick();
    sv = 1'b0;
    tick();
    n_checks++;
    if ({ctl, ovr} !== {S_IDLE, 1'b0}) begin
      n_fail++; $display("FAIL idle_sample_ignored: got %b want %b", {ctl, ovr}, {S_IDLE, 1'b0});
    end
  endtask

`ifdef COEFF_SYMM_EN
  task automatic test_load();
    int t;
    upd = 1'b1; tick(); upd = 1'b0; t = 0;
    n_checks++;
    if (ctl !== S_ARM) begin n_fail++; $display("FAIL load_arm: got %b want %b", ctl, S_ARM); end
    tick(); t++;
    n_checks++;
    if ({ctl, addr, wdat} !== {S_PRIME, 22'd0}) begin
      n_fail++; $display("FAIL load_prime: got %b/%h/%h want %b/0/0", ctl, addr, wdat, S_PRIME);
    end
    tick(); t++;
    n_checks++;
    if (ctl !== S_LHOLD) begin n_fail++; $display("FAIL load_hold: got %b want %b", ctl, S_LHOLD); end
    for (int k = 0; k < (N + 1) / 2; k++) begin
      cv = 1'b1; cd = 16'(16'h0100 + k);
      tick(); t++;
      n_checks++;
      if ({ctl, addr, wdat} !== {S_LLAST, 6'(k), cd}) begin
        n_fail++; $display("FAIL symm_write k=%0d: got %b/%0d/%h want %b/%0d/%h", k, ctl, addr, wdat, S_LLAST, k, cd);
      end
      if (k < N / 2) begin
        tick(); t++;
        n_checks++;
        if ({ctl, addr, wdat} !== {S_LWR, 6'(N - 1 - k), cd}) begin
          n_fail++; $display("FAIL symm_mirror k=%0d: got %b/%0d/%h want %b/%0d/%h", k, ctl, addr, wdat, S_LWR, N - 1 - k, cd);
        end
      end
    end
    cv = 1'b0; cd = '0;
    while (busy && t < 100) begin tick(); t++; end
    n_checks++;
    if ({t, ctl} !== {32'd36, S_WAIT}) begin
      n_fail++; $display("FAIL symm_reload_time: got %0d/%b want 36/%b", t, ctl, S_WAIT);
    end
  endtask
`else
  task automatic test_load();
    int t;
    upd = 1'b1; tick(); upd = 1'b0; t = 0;
    n_checks++;
    if (ctl !== S_ARM) begin n_fail++; $display("FAIL load_arm: got %b want %b", ctl, S_ARM); end
    tick(); t++;
    n_checks++;
    if ({ctl, addr, wdat} !== {S_PRIME, 22'd0}) begin
      n_fail++; $display("FAIL load_prime: got %b/%h/%h want %b/0/0", ctl, addr, wdat, S_PRIME);
    end
    tick(); t++;
    n_checks++;
    if (ctl !== S_LHOLD) begin n_fail++; $display("FAIL load_hold: got %b want %b", ctl, S_LHOLD); end
    for (int k = 0; k < N; k++) begin
      cv = 1'b1; cd = 16'(k + 1);
      tick(); t++;
      n_checks++;
      if ({ctl, addr, wdat} !== {(k == N - 1) ? S_LLAST : S_LWR, 6'(k), 16'(k + 1)}) begin
        n_fail++; $display("FAIL load_write k=%0d: got %b/%0d/%h want %b/%0d/%h", k, ctl, addr, wdat, (k == N - 1) ? S_LLAST : S_LWR, k, k + 1);
      end
    end
    cv = 1'b0; cd = '0;
    while (busy && t < 100) begin tick(); t++; end
    n_checks++;
    if ({t, ctl} !== {32'd36, S_WAIT}) begin
      n_fail++; $display("FAIL reload_time: got %0d/%b want 36/%b", t, ctl, S_WAIT);
    end
  endtask
`endif

  task automatic test_sweep();
    sv = 1'b1; tick(); sv = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({ctl, addr, done} !== {S_READ, 6'(i), (i == N - 1)}) begin
        n_fail++; $display("FAIL sweep i=%0d: got %b/%0d/%b want %b/%0d/%b", i, ctl, addr, done, S_READ, i, (i == N - 1));
      end
      tick();
    end
    n_checks++;
    if ({ctl, done, ovr} !== {S_WAIT, 2'b00}) begin
      n_fail++; $display("FAIL sweep_end: got %b want %b", {ctl, done, ovr}, {S_WAIT, 2'b00});
    end
  endtask

  task automatic test_overrun();
    sv = 1'b1; tick(); sv = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({ctl, addr, ovr} !== {S_READ, 6'(i), (i > 5)}) begin
        n_fail++; $display("FAIL overrun_sweep i=%0d: got %b/%0d/%b want %b/%0d/%b", i, ctl, addr, ovr, S_READ, i, (i > 5));
      end
      sv = (i == 5);
      tick();
    end
    sv = 1'b0;
    n_checks++;
    if ({ctl, ovr} !== {S_WAIT, 1'b1}) begin
      n_fail++; $display("FAIL overrun_sticky: got %b want %b", {ctl, ovr}, {S_WAIT, 1'b1});
    end
  endtask

  task automatic test_upd_in_read();
    sv = 1'b1; tick(); sv = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({ctl, addr, done} !== {S_READ, 6'(i), (i == N - 1)}) begin
        n_fail++; $display("FAIL pend_sweep i=%0d: got %b/%0d/%b want %b/%0d/%b", i, ctl, addr, done, S_READ, i, (i == N - 1));
      end
      upd = (i == 20);
      tick();
    end
    upd = 1'b0;
    n_checks++;
    if (ctl !== S_ARM) begin n_fail++; $display("FAIL pend_arm: got %b want %b", ctl, S_ARM); end
    tick();
    n_checks++;
    if (ctl !== S_PRIME) begin n_fail++; $display("FAIL pend_prime: got %b want %b", ctl, S_PRIME); end
    tick();
    n_checks++;
    if (ctl !== S_LHOLD) begin n_fail++; $display("FAIL pend_load: got %b want %b", ctl, S_LHOLD); end
  endtask

  task automatic test_reset_mid_load();
    cv = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cd = 16'(16'h0A00 + k);
      tick();
    end
    n_checks++;
    if ({flag, csn, wrn} !== 3'b100) begin
      n_fail++; $display("FAIL midload_writing: got %b want 100", {flag, csn, wrn});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ctl, done, ovr, addr, wdat} !== {S_IDLE, 2'b00, 22'd0}) begin
      n_fail++; $display("FAIL midload_reset: got %b/%h/%h want %b/0/0", {ctl, done, ovr}, addr, wdat, {S_IDLE, 2'b00});
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (ctl !== S_IDLE) begin n_fail++; $display("FAIL midload_no_write k=%0d: got %b want %b", k, ctl, S_IDLE); end
    end
    cv = 1'b0;
  endtask

  task automatic test_collision();
    n_checks++;
    if ({ctl, ovr} !== {S_WAIT, 1'b0}) begin
      n_fail++; $display("FAIL collide_pre: got %b want %b", {ctl, ovr}, {S_WAIT, 1'b0});
    end
    upd = 1'b1; sv = 1'b1;
    tick();
    upd = 1'b0; sv = 1'b0;
    n_checks++;
    if ({ctl, ovr} !== {S_ARM, 1'b1}) begin
      n_fail++; $display("FAIL collide_arm: got %b want %b", {ctl, ovr}, {S_ARM, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_sweep();
    test_overrun();
    test_upd_in_read();
    test_reset_mid_load();
    test_load();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
